// File: rtl/rx_deserializer.sv
// Serial frame receiver: start, 8 data bits LSB first, parity, stop -> 9-bit word.
// Define STOP_CHECK_EN to flag bad stop bits on frame_err; otherwise the stop sample is ignored.
module rx_deserializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       rx,
  output logic [8:0] data_out,
  output logic       valid,
  output logic       busy,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [8:0]    shift, shift_nx;
  logic [8:0]    data_nx;
  logic          valid_nx;
  logic          rx_m, rx_s;
`ifdef STOP_CHECK_EN
  logic          hold, hold_nx;
  logic          ferr_nx;
  logic          ferr_q;
`endif

  // Synchronizer flops idle high so reset never looks like a start bit
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      shift    <= 9'd0;
      data_out <= 9'd0;
      valid    <= 1'b0;
`ifdef STOP_CHECK_EN
      hold     <= 1'b0;
      ferr_q   <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= bit_idx_nx;
      shift    <= shift_nx;
      data_out <= data_nx;
      valid    <= valid_nx;
`ifdef STOP_CHECK_EN
      hold     <= hold_nx;
      ferr_q   <= ferr_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    data_nx    = data_out;
    valid_nx   = 1'b0;
`ifdef STOP_CHECK_EN
    hold_nx    = hold;
    ferr_nx    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        // Mid-start-bit recheck rejects short glitches
        if (cnt == HALF_M1) begin
          cnt_nx = '0;
          if (!rx_s) begin
            state_nx   = DATA;
            bit_idx_nx = 3'd0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nx            = '0;
          shift_nx[bit_idx] = rx_s;
          bit_idx_nx        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = PARITY;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_nx      = '0;
          shift_nx[8] = rx_s;
          state_nx    = STOP;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      STOP: begin
`ifdef STOP_CHECK_EN
        // After a bad stop bit, wait for the line to return idle before rearming
        if (hold) begin
          if (rx_s) begin
            hold_nx  = 1'b0;
            state_nx = IDLE;
          end
        end else if (cnt == FULL_M1) begin
          cnt_nx = '0;
          if (rx_s) begin
            data_nx  = shift;
            valid_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_nx = 1'b1;
            hold_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
`else
        if (cnt == FULL_M1) begin
          cnt_nx   = '0;
          data_nx  = shift;
          valid_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef STOP_CHECK_EN
  assign frame_err = ferr_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_deserializer.sv
// Randomized scoreboard bench for rx_deserializer: frames are pushed as expected
// words with their due cycle; a negedge monitor pops and compares on valid/frame_err.
module tb_rx_deserializer;

  localparam int CPB = 16;
  // rx fall -> 2 sync edges -> IDLE->START edge -> stop sample edge
  localparam int LAT = 3 + CPB / 2 + 10 * CPB;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       rx = 1'b1;
  logic [8:0] data_out;
  logic       valid;
  logic       busy;
  logic       frame_err;

  rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .rx       (rx),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] word;
    int         due;
    bit         err;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_chk = 0;
  int         n_pass = 0;
  int         hold_bad = 0;
  logic [8:0] model_out = 9'd0;
  logic       prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (arst_n) begin
      if (valid || frame_err) begin
        check("valid_ferr_exclusive", 32'(valid && frame_err), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_kind_ferr", 32'(frame_err), 32'(e.err));
          check("out_cycle", 32'(cyc), 32'(e.due));
          if (!e.err) begin
            check("data_out", 32'(data_out), 32'(e.word));
            model_out = e.word;
          end else begin
            check("data_kept_on_ferr", 32'(data_out), 32'(model_out));
          end
        end
      end else if (data_out !== model_out) begin
        hold_bad++;
      end
      if (valid && prev_valid) hold_bad++;
    end
    prev_valid = valid;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; each bit is held exactly CPB cycles
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input bit exp_err);
    logic [10:0] bits;
    bits = {stop, p, d, 1'b0};
    sb.push_back('{word: {p, d}, due: cyc + LAT, err: exp_err});
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    repeat (len) @(posedge clk);
    #1;
    idle(20);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rp;
    int         wait_cnt;

    arst_n = 1'b0;
    rx = 1'b1;
    #12;
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    idle(5);

    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("busy_after_a5", 32'(busy), 32'd0);

    send_frame(8'h01, 1'b0, 1'b1, 1'b0);
    idle(3);

    glitch(4);
    check("glitch_data_kept", 32'(data_out), 32'h001);
    check("glitch_busy", 32'(busy), 32'd0);

    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    idle(5);

`ifdef STOP_CHECK_EN
    send_frame(8'h66, 1'b1, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    check("ferr_busy_held", 32'(busy), 32'd1);
    idle(10);
    check("ferr_busy_released", 32'(busy), 32'd0);
    check("ferr_data_kept", 32'(data_out), 32'h0FF);
`else
    send_frame(8'h66, 1'b1, 1'b0, 1'b0);
    idle(30);
    check("badstop_busy", 32'(busy), 32'd0);
`endif

    for (int i = 0; i < 12; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      if ($urandom_range(0, 3) == 0) glitch(int'($urandom_range(1, 6)));
      idle(int'($urandom_range(0, 8)));
      send_frame(rd, rp, 1'b1, 1'b0);
    end
    idle(4);

    // Abort a frame halfway through data bit 4
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int b = 0; b < 4; b++) begin
      rx = 1'($urandom);
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    check("busy_mid_frame", 32'(busy), 32'd1);
    arst_n = 1'b0;
    model_out = 9'd0;
    #1;
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    arst_n = 1'b1;
    idle(5);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    idle(10);
    check("final_data_out", 32'(data_out), 32'h05A);

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 400) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("hold_violations", 32'(hold_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
